ks_serial_addsub: RTL



---
 rtl/ks_serial_addsub_pkg.sv | 24 ++
 rtl/kogge_stone_4bit.sv | 44 ++++
 rtl/ks_serial_addsub.sv | 102 ++++++++++
 3 files changed

// File: rtl/ks_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial Kogge-Stone adder/subtractor.
package ks_serial_addsub_pkg;

    // Width of one datapath slice
    localparam int NIBBLE_W = 4;

    // Operation select encoding
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign, result does not
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/kogge_stone_4bit.sv
// 4-bit Kogge-Stone adder with carry-in; the per-cycle slice of the serial unit.
module kogge_stone_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] sum
);

    logic [3:0] p;
    logic [3:0] g0;
    logic [3:0] p0;
    logic [3:0] g1;
    logic [3:0] p1;
    logic [3:0] g2;

    // Two-level parallel prefix; cin is folded into bit 0 generate so that
    // every prefix term g2[i] is the carry out of bit i.
    always_comb begin
        p  = A ^ B;
        g0 = A & B;
        p0 = p;
        g0[0] = g0[0] | (p[0] & cin);

        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 4; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end

        g2 = g1;
        for (int i = 2; i < 4; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
        end
    end

    // Sum uses the carry into each bit position
    always_comb begin
        sum  = p ^ {g2[2:0], cin};
        cout = g2[3];
    end

endmodule

// File: rtl/ks_serial_addsub.sv
// Multi-cycle two's-complement adder/subtractor: one nibble per clock, LSB
// first, through a single Kogge-Stone slice with a registered inter-nibble carry.
module ks_serial_addsub
    import ks_serial_addsub_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  carry;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;

    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   slice_sum;
    logic                  slice_cout;
    logic                  last;

    // Select the nibble pair addressed by the counter
    always_comb begin
        a_nib = a_q[NIBBLE_W*cnt +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*cnt +: NIBBLE_W];
        last  = (cnt == CW'(NIBBLES - 1));
    end

    kogge_stone_4bit u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .cin  (carry),
        .cout (slice_cout),
        .sum  (slice_sum)
    );

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        // Subtract as a + ~b + 1: invert here, +1 via carry-in
                        b_q   <= b ^ {W{op}};
                        carry <= op;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    result[NIBBLE_W*cnt +: NIBBLE_W] <= slice_sum;
                    carry <= slice_cout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout  <= slice_cout;
                        ovf   <= signed_ovf(a_q[W-1], b_q[W-1], slice_sum[NIBBLE_W-1]);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
